// File: rtl/trace_capture_ctrl_pkg.sv
// Shared widths, state encoding and helpers for the trace capture sequencer.
// The state encodings are the values reg_trace reads back from O_state.
package trace_capture_ctrl_pkg;

  localparam int MATCH_RULES   = 8;
  localparam int COUNT_WIDTH   = 16;
  localparam int TIMEOUT_WIDTH = 24;
  localparam int HOLDOFF_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_ARMED     = 3'd2,
    ST_HOLDOFF   = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_DONE      = 3'd5
  } trace_state_e;

  function automatic logic state_is_busy(input trace_state_e s);
    return (s == ST_WAIT_SYNC) || (s == ST_ARMED) || (s == ST_HOLDOFF) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/trace_downcounter.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
// One-cycle latency from load/enable to count; no backpressure.
module trace_downcounter #(
  parameter int pWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [pWIDTH-1:0] i_load_val,
  input  logic              i_en,
  output logic              o_zero
);

  logic [pWIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - pWIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: arm -> sync -> trigger -> holdoff -> N frame writes -> done.
// FIFO write is combinational (0 latency); a full FIFO drops the frame and ends capture. Optional armed timeout: TRACE_CAPTURE_TIMEOUT_EN.
module trace_capture_ctrl
  import trace_capture_ctrl_pkg::*;
#(
  parameter int pMATCH_RULES   = MATCH_RULES,
  parameter int pCOUNT_WIDTH   = COUNT_WIDTH,
  parameter int pTIMEOUT_WIDTH = TIMEOUT_WIDTH
) (
  input  logic                      trace_clk,
  input  logic                      reset_i,
  input  logic                      I_arm,
  input  logic                      I_abort,
  input  logic                      I_synchronized,
  input  logic [pMATCH_RULES-1:0]   I_match,
  input  logic [pMATCH_RULES-1:0]   I_trig_enable,
  input  logic                      I_soft_trig,
  input  logic                      I_soft_trig_enable,
  input  logic                      I_data_valid,
  input  logic                      I_fifo_full,
  input  logic [pCOUNT_WIDTH-1:0]   I_max_samples,
  input  logic [HOLDOFF_WIDTH-1:0]  I_holdoff,
  input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
  output logic                      O_fifo_wr,
  output logic                      O_trig_out,
  output logic                      O_busy,
  output logic                      O_done,
  output logic                      O_overflow,
  output logic                      O_timed_out,
  output logic [2:0]                O_state,
  output logic [pCOUNT_WIDTH-1:0]   O_sample_count
);

  trace_state_e             r_state, w_next_state;
  logic [pCOUNT_WIDTH-1:0]  r_max, r_count;
  logic [HOLDOFF_WIDTH-1:0] r_holdoff;
  logic                     r_trig_out, r_done, r_overflow;
  logic                     w_arm, w_trig, w_write, w_full_drop, w_count_hit;
  logic                     w_hold_zero, w_timeout_hit;

  assign w_arm       = I_arm && !I_abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_trig      = (r_state == ST_ARMED) &&
                       ((|(I_match & I_trig_enable)) || (I_soft_trig && I_soft_trig_enable));
  assign w_write     = !reset_i && I_data_valid && !I_fifo_full && (r_state == ST_CAPTURE);
  assign w_full_drop = I_data_valid && I_fifo_full && (r_state == ST_CAPTURE);
  assign w_count_hit = w_write && (r_max != '0) && ((r_count + pCOUNT_WIDTH'(1)) == r_max);

  // Loaded with holdoff-1 so HOLDOFF lasts exactly holdoff cycles.
  trace_downcounter #(.pWIDTH(HOLDOFF_WIDTH)) u_holdoff_cnt (
    .i_clk      (trace_clk),
    .i_reset    (reset_i),
    .i_load     (w_trig),
    .i_load_val (r_holdoff - HOLDOFF_WIDTH'(1)),
    .i_en       (r_state == ST_HOLDOFF),
    .o_zero     (w_hold_zero)
  );

`ifdef TRACE_CAPTURE_TIMEOUT_EN
  logic [pTIMEOUT_WIDTH-1:0] r_timeout;
  logic                      r_timed_out, w_timeout_zero;

  trace_downcounter #(.pWIDTH(pTIMEOUT_WIDTH)) u_timeout_cnt (
    .i_clk      (trace_clk),
    .i_reset    (reset_i),
    .i_load     (w_arm),
    .i_load_val (I_timeout - pTIMEOUT_WIDTH'(1)),
    .i_en       ((r_state == ST_WAIT_SYNC) || (r_state == ST_ARMED)),
    .o_zero     (w_timeout_zero)
  );

  // A trigger seen on the expiry cycle still wins.
  assign w_timeout_hit = (r_timeout != '0) && w_timeout_zero &&
                         ((r_state == ST_WAIT_SYNC) || ((r_state == ST_ARMED) && !w_trig));

  always_ff @(posedge trace_clk) begin
    if (reset_i) begin
      r_timeout   <= '0;
      r_timed_out <= 1'b0;
    end else if (w_arm) begin
      r_timeout   <= I_timeout;
      r_timed_out <= 1'b0;
    end else if (w_timeout_hit && !I_abort) begin
      r_timed_out <= 1'b1;
    end
  end

  assign O_timed_out = r_timed_out;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^I_timeout;
  assign w_timeout_hit    = 1'b0;
  assign O_timed_out      = 1'b0;
`endif

  always_ff @(posedge trace_clk) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (I_abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (I_arm) w_next_state = ST_WAIT_SYNC;
        ST_WAIT_SYNC: begin
          if (w_timeout_hit)       w_next_state = ST_DONE;
          else if (I_synchronized) w_next_state = ST_ARMED;
        end
        ST_ARMED: begin
          if (w_trig)             w_next_state = (r_holdoff != '0) ? ST_HOLDOFF : ST_CAPTURE;
          else if (w_timeout_hit) w_next_state = ST_DONE;
        end
        ST_HOLDOFF: if (w_hold_zero) w_next_state = ST_CAPTURE;
        ST_CAPTURE: if (w_count_hit || w_full_drop || !I_synchronized) w_next_state = ST_DONE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge trace_clk) begin
    if (reset_i) begin
      r_max      <= '0;
      r_count    <= '0;
      r_holdoff  <= '0;
      r_trig_out <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_trig_out <= w_trig;
      if (w_arm) begin
        r_max      <= I_max_samples;
        r_holdoff  <= I_holdoff;
        r_count    <= '0;
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        // Unlimited captures saturate rather than wrap.
        if (w_write && (r_count != '1)) r_count <= r_count + pCOUNT_WIDTH'(1);
        if (w_full_drop && !I_abort)    r_overflow <= 1'b1;
        if ((r_state != ST_DONE) && (w_next_state == ST_DONE)) r_done <= 1'b1;
      end
    end
  end

  assign O_fifo_wr      = w_write;
  assign O_trig_out     = r_trig_out;
  assign O_busy         = state_is_busy(r_state);
  assign O_done         = r_done;
  assign O_overflow     = r_overflow;
  assign O_state        = r_state;
  assign O_sample_count = r_count;

endmodule
